// File: rtl/calc_sequencer.sv
// Keypad sequencer for the calculadora datapath: builds decimal operands and the operator
// from key strobes, runs the datapath for a fixed settle time, then captures and flags the result.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_ENTER_A | collecting digits of operand A (reset state)
// S_ENTER_B | operator latched, collecting digits of operand B
// S_EXEC    | datapath out of reset, settle timer counting down
// S_SHOW    | result captured and displayed; chaining allowed
// S_ERROR   | divide-by-zero detected, only clear leaves
module calc_sequencer #(
  parameter int MAX_DIGITS = 5,
  parameter int SETTLE     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [26:0] dp_s,
  output logic [17:0] dp_a,
  output logic [17:0] dp_b,
  output logic [1:0]  dp_op,
  output logic        dp_rst,
  output logic [26:0] result,
  output logic        result_valid,
  output logic        busy,
  output logic        neg,
  output logic        err,
  output logic [26:0] disp_val
);

  localparam logic [2:0] S_ENTER_A = 3'd0;
  localparam logic [2:0] S_ENTER_B = 3'd1;
  localparam logic [2:0] S_EXEC    = 3'd2;
  localparam logic [2:0] S_SHOW    = 3'd3;
  localparam logic [2:0] S_ERROR   = 3'd4;

  localparam int DW = $clog2(MAX_DIGITS + 1);
  localparam int TW = $clog2(SETTLE) + 1;

  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  logic [2:0]    state, state_n;
  logic [17:0]   a_n, b_n;
  logic [1:0]    op_n;
  logic [DW-1:0] cnt_a, cnt_a_n, cnt_b, cnt_b_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [26:0]   result_n, disp_n;
  logic          rv_n, neg_n, err_n;

  logic        is_digit, is_op, is_eq, is_clr;
  logic [17:0] digit;
  logic [1:0]  key_op;

  assign is_digit = key_code < 4'd10;
  assign is_op    = (key_code >= 4'd10) && (key_code <= 4'd13);
  assign is_eq    = key_code == 4'd14;
  assign is_clr   = key_code == 4'd15;
  assign digit    = {14'd0, key_code};
  assign key_op   = 2'(key_code - 4'd10);

  assign busy   = state == S_EXEC;
  assign dp_rst = state != S_EXEC;

  always_comb begin
    state_n  = state;
    a_n      = dp_a;
    b_n      = dp_b;
    op_n     = dp_op;
    cnt_a_n  = cnt_a;
    cnt_b_n  = cnt_b;
    tmr_n    = tmr;
    result_n = result;
    rv_n     = 1'b0;
    neg_n    = neg;
    err_n    = err;

    if (key_valid && is_clr) begin
      state_n  = S_ENTER_A;
      a_n      = '0;
      b_n      = '0;
      op_n     = '0;
      cnt_a_n  = '0;
      cnt_b_n  = '0;
      tmr_n    = '0;
      result_n = '0;
      neg_n    = 1'b0;
      err_n    = 1'b0;
    end else begin
      case (state)
        S_ENTER_A: if (key_valid) begin
          if (is_digit && cnt_a != DW'(MAX_DIGITS)) begin
            a_n     = dp_a * 18'd10 + digit;
            cnt_a_n = cnt_a + DW'(1);
          end else if (is_op) begin
            op_n    = key_op;
            b_n     = '0;
            cnt_b_n = '0;
            state_n = S_ENTER_B;
          end
        end
        S_ENTER_B: if (key_valid) begin
          if (is_digit && cnt_b != DW'(MAX_DIGITS)) begin
            b_n     = dp_b * 18'd10 + digit;
            cnt_b_n = cnt_b + DW'(1);
          end else if (is_op && cnt_b == '0) begin
            op_n = key_op;
          end else if (is_eq && cnt_b != '0) begin
            if (dp_op == OP_DIV && dp_b == '0) begin
              state_n = S_ERROR;
              err_n   = 1'b1;
            end else begin
              state_n = S_EXEC;
              tmr_n   = TW'(SETTLE - 1);
            end
          end
        end
        S_EXEC: begin
          if (tmr == '0) begin
            result_n = dp_s;
            rv_n     = 1'b1;
            neg_n    = (dp_op == OP_SUB) && (dp_a < dp_b);
            err_n    = (dp_op == OP_MUL) && (dp_s == '0) && (dp_a != '0) && (dp_b != '0);
            state_n  = S_SHOW;
          end else begin
            tmr_n = tmr - TW'(1);
          end
        end
        S_SHOW: if (key_valid) begin
          if (is_digit) begin
            a_n     = digit;
            cnt_a_n = DW'(1);
            b_n     = '0;
            cnt_b_n = '0;
            state_n = S_ENTER_A;
          end else if (is_op && result <= 27'd99999 && !neg && !err) begin
            a_n     = result[17:0];
            cnt_a_n = '0;
            b_n     = '0;
            cnt_b_n = '0;
            op_n    = key_op;
            state_n = S_ENTER_B;
          end
        end
        S_ERROR: ;
        default: state_n = S_ENTER_A;
      endcase
    end
  end

  // Display follows the next-state values so it stays a plain register.
  always_comb begin
    disp_n = disp_val;
    case (state_n)
      S_ENTER_A: disp_n = 27'(a_n);
      S_ENTER_B: disp_n = (cnt_b_n != '0) ? 27'(b_n) : 27'(a_n);
      S_SHOW:    disp_n = result_n;
      S_ERROR:   disp_n = '0;
      default:   disp_n = disp_val;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_ENTER_A;
      dp_a         <= '0;
      dp_b         <= '0;
      dp_op        <= '0;
      cnt_a        <= '0;
      cnt_b        <= '0;
      tmr          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      neg          <= 1'b0;
      err          <= 1'b0;
      disp_val     <= '0;
    end else begin
      state        <= state_n;
      dp_a         <= a_n;
      dp_b         <= b_n;
      dp_op        <= op_n;
      cnt_a        <= cnt_a_n;
      cnt_b        <= cnt_b_n;
      tmr          <= tmr_n;
      result       <= result_n;
      result_valid <= rv_n;
      neg          <= neg_n;
      err          <= err_n;
      disp_val     <= disp_n;
    end
  end

endmodule
